// File: rtl/sample_stream_arbiter.sv
// Two-channel round-robin sample arbiter feeding a shared filter datapath.
// Grants are spaced by a programmable pace interval; every output is registered.
module sample_stream_arbiter #(
    parameter int unsigned SAMPLE_PERIOD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] in0_z,
    input  logic        in0_z_stb,
    output logic        in0_z_ack,
    input  logic [31:0] in1_z,
    input  logic        in1_z_stb,
    output logic        in1_z_ack,
    output logic [31:0] out_z,
    output logic        out_z_ch,
    output logic        out_z_stb,
    input  logic        out_z_ack,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
);

    typedef enum logic [1:0] {StIdle, StAck, StHold, StPace} state_e;

    // The first PACE cycle is already the cycle after acceptance, hence the -2.
    localparam logic [15:0] PaceLoad = (SAMPLE_PERIOD >= 2) ? 16'(SAMPLE_PERIOD - 2) : 16'd0;

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [15:0] pace_q, pace_d;
    logic [31:0] out_z_q, out_z_d;
    logic        out_ch_q, out_ch_d;
    logic        out_stb_q, out_stb_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;
    logic        grant1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        pace_d    = pace_q;
        out_z_d   = out_z_q;
        out_ch_d  = out_ch_q;
        out_stb_d = out_stb_q;
        ack0_d    = ack0_q;
        ack1_d    = ack1_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        // Channel 1 wins when it alone requests, or on contention when the pointer names it.
        grant1    = in1_z_stb && (!in0_z_stb || ptr_q);

        case (state_q)
            StIdle: begin
                if (enable && (in0_z_stb || in1_z_stb)) begin
                    out_z_d  = grant1 ? in1_z : in0_z;
                    out_ch_d = grant1;
                    ack0_d   = !grant1;
                    ack1_d   = grant1;
                    state_d  = StAck;
                end
            end
            StAck: begin
                ack0_d    = 1'b0;
                ack1_d    = 1'b0;
                out_stb_d = 1'b1;
                state_d   = StHold;
            end
            StHold: begin
                if (out_z_ack) begin
                    out_stb_d = 1'b0;
                    ptr_d     = !out_ch_q;
                    if (out_ch_q) begin
                        cnt1_d = cnt1_q + 16'd1;
                    end else begin
                        cnt0_d = cnt0_q + 16'd1;
                    end
                    if (SAMPLE_PERIOD == 1) begin
                        state_d = StIdle;
                    end else begin
                        pace_d  = PaceLoad;
                        state_d = StPace;
                    end
                end
            end
            StPace: begin
                if (pace_q == 16'd0) begin
                    state_d = StIdle;
                end else begin
                    pace_d = pace_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= 1'b0;
            pace_q    <= 16'd0;
            out_z_q   <= 32'd0;
            out_ch_q  <= 1'b0;
            out_stb_q <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            cnt0_q    <= 16'd0;
            cnt1_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            pace_q    <= pace_d;
            out_z_q   <= out_z_d;
            out_ch_q  <= out_ch_d;
            out_stb_q <= out_stb_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    assign in0_z_ack = ack0_q;
    assign in1_z_ack = ack1_q;
    assign out_z     = out_z_q;
    assign out_z_ch  = out_ch_q;
    assign out_z_stb = out_stb_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_sample_stream_arbiter.sv
// Directed bench for sample_stream_arbiter: one instance at the default pace,
// one at SAMPLE_PERIOD=1.
module tb_sample_stream_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        enable, in0_z_stb, in1_z_stb, out_z_ack;
    logic [31:0] in0_z, in1_z;
    logic        in0_z_ack, in1_z_ack, out_z_ch, out_z_stb;
    logic [31:0] out_z;
    logic [15:0] cnt0, cnt1;

    logic        b_enable, b_in0_z_stb, b_in1_z_stb, b_out_z_ack;
    logic [31:0] b_in0_z, b_in1_z;
    logic        b_in0_z_ack, b_in1_z_ack, b_out_z_ch, b_out_z_stb;
    logic [31:0] b_out_z;
    logic [15:0] b_cnt0, b_cnt1;

    sample_stream_arbiter #(.SAMPLE_PERIOD(4)) dut_a (
        .clk(clk), .rst(rst), .enable(enable),
        .in0_z(in0_z), .in0_z_stb(in0_z_stb), .in0_z_ack(in0_z_ack),
        .in1_z(in1_z), .in1_z_stb(in1_z_stb), .in1_z_ack(in1_z_ack),
        .out_z(out_z), .out_z_ch(out_z_ch), .out_z_stb(out_z_stb), .out_z_ack(out_z_ack),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    sample_stream_arbiter #(.SAMPLE_PERIOD(1)) dut_b (
        .clk(clk), .rst(rst), .enable(b_enable),
        .in0_z(b_in0_z), .in0_z_stb(b_in0_z_stb), .in0_z_ack(b_in0_z_ack),
        .in1_z(b_in1_z), .in1_z_stb(b_in1_z_stb), .in1_z_ack(b_in1_z_ack),
        .out_z(b_out_z), .out_z_ch(b_out_z_ch), .out_z_stb(b_out_z_stb),
        .out_z_ack(b_out_z_ack), .cnt0(b_cnt0), .cnt1(b_cnt1)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_stb_a(input int max, output int n);
        n = 0;
        while (out_z_stb !== 1'b1 && n < max) begin
            step(1);
            n++;
        end
        check("a_stb_seen", out_z_stb, 1);
    endtask

    task automatic wait_stb_b(input int max, output int n);
        n = 0;
        while (b_out_z_stb !== 1'b1 && n < max) begin
            step(1);
            n++;
        end
        check("b_stb_seen", b_out_z_stb, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 0; in0_z_stb = 0; in1_z_stb = 0; out_z_ack = 0; in0_z = 0; in1_z = 0;
        b_enable = 0; b_in0_z_stb = 0; b_in1_z_stb = 0; b_out_z_ack = 0;
        b_in0_z = 0; b_in1_z = 0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    // Acks are mutually exclusive and never overlap a pending output.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("ack_excl", (in0_z_ack && in1_z_ack) || ((in0_z_ack || in1_z_ack) && out_z_stb), 0);
        end
    end

    initial begin
        int n;
        do_reset();
        mon_en = 1'b1;
        check("rst_out_z", out_z, 0);
        check("rst_out_ch", out_z_ch, 0);
        check("rst_out_stb", out_z_stb, 0);
        check("rst_ack0", in0_z_ack, 0);
        check("rst_ack1", in1_z_ack, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);

        // Single channel, immediate downstream ack.
        in0_z = 32'h0000_1234; in0_z_stb = 1; enable = 1; out_z_ack = 1;
        step(1);
        check("t1_ack0_hi", in0_z_ack, 1);
        check("t1_ack1_lo", in1_z_ack, 0);
        check("t1_stb_lo", out_z_stb, 0);
        step(1);
        check("t1_ack0_pulse", in0_z_ack, 0);
        check("t1_stb_hi", out_z_stb, 1);
        check("t1_out_z", out_z, 32'h1234);
        check("t1_out_ch", out_z_ch, 0);
        step(1);
        check("t1_stb_clr", out_z_stb, 0);
        check("t1_cnt0", cnt0, 1);
        wait_stb_a(20, n);
        check("t1_spacing", 32'(n + 1), 6);
        in0_z_stb = 0;
        step(10);
        check("t1_cnt0_final", cnt0, 2);

        // Contention: grants alternate starting from channel 0.
        do_reset();
        in0_z = 32'hA; in1_z = 32'hB; in0_z_stb = 1; in1_z_stb = 1; enable = 1; out_z_ack = 1;
        for (int i = 0; i < 4; i++) begin
            wait_stb_a(20, n);
            check("t2_ch", out_z_ch, 32'(i % 2));
            check("t2_data", out_z, (i % 2) ? 32'hB : 32'hA);
            step(1);
        end
        in0_z_stb = 0; in1_z_stb = 0;
        check("t2_cnt0", cnt0, 2);
        check("t2_cnt1", cnt1, 2);
        step(10);

        // Backpressure: output held, late requester held off.
        do_reset();
        in0_z = 32'h55; in0_z_stb = 1; enable = 1; out_z_ack = 0;
        wait_stb_a(10, n);
        in1_z = 32'h66; in1_z_stb = 1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("t3_stb", out_z_stb, 1);
            check("t3_data", out_z, 32'h55);
            check("t3_ack0", in0_z_ack, 0);
            check("t3_ack1", in1_z_ack, 0);
        end
        out_z_ack = 1;
        step(1);
        check("t3_stb_clr", out_z_stb, 0);
        check("t3_cnt0", cnt0, 1);
        in0_z_stb = 0; in1_z_stb = 0;
        step(10);

        // Enable dropped during HOLD, then restored.
        do_reset();
        in0_z = 32'h11; in1_z = 32'h22; in0_z_stb = 1; in1_z_stb = 1; enable = 1; out_z_ack = 0;
        wait_stb_a(10, n);
        check("t4_first_ch", out_z_ch, 0);
        enable = 0;
        step(3);
        out_z_ack = 1;
        step(1);
        check("t4_cnt0", cnt0, 1);
        for (int i = 0; i < 30; i++) begin
            step(1);
            check("t4_no_stb", out_z_stb, 0);
            check("t4_no_ack", in0_z_ack | in1_z_ack, 0);
        end
        check("t4_cnt0_hold", cnt0, 1);
        check("t4_cnt1_hold", cnt1, 0);
        enable = 1;
        wait_stb_a(10, n);
        check("t4_resume_ch", out_z_ch, 1);
        check("t4_resume_data", out_z, 32'h22);
        step(1);
        in0_z_stb = 0; in1_z_stb = 0;
        step(10);

        // Counter wrap from a preloaded 65535.
        do_reset();
        force dut_a.cnt0_q = 16'hFFFF;
        step(1);
        release dut_a.cnt0_q;
        in0_z = 32'h7; in0_z_stb = 1; enable = 1; out_z_ack = 1;
        wait_stb_a(10, n);
        step(1);
        in0_z_stb = 0;
        check("t5_wrap_cnt0", cnt0, 0);
        check("t5_wrap_cnt1", cnt1, 0);
        step(10);

        // Reset asserted while in ACK.
        in0_z = 32'h99; in0_z_stb = 1;
        step(1);
        check("t5_in_ack", in0_z_ack, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_ack0", in0_z_ack, 0);
        check("t5_rst_out_z", out_z, 0);
        check("t5_rst_ch", out_z_ch, 0);
        check("t5_rst_stb", out_z_stb, 0);
        in0_z_stb = 0;
        step(1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t5_no_stale_stb", out_z_stb, 0);
            check("t5_no_stale_ack", in0_z_ack | in1_z_ack, 0);
        end

        // SAMPLE_PERIOD=1: a grant every 3 clocks.
        b_in1_z = 32'hBEEF; b_in1_z_stb = 1; b_out_z_ack = 1; b_enable = 1;
        wait_stb_b(10, n);
        check("t6_ch", b_out_z_ch, 1);
        check("t6_data", b_out_z, 32'hBEEF);
        for (int i = 0; i < 3; i++) begin
            step(1);
            wait_stb_b(10, n);
            check("t6_spacing", 32'(n + 1), 3);
        end
        b_in1_z_stb = 0;
        step(5);
        check("t6_cnt1", b_cnt1, 4);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_stream_arbiter.md
SAMPLE_STREAM_ARBITER -- requirements
Module: sample_stream_arbiter

Interface
REQ-001 SHALL have parameter SAMPLE_PERIOD, default 4: minimum clocks from one output acceptance to the next arbitration (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1: permits new arbitration when high.
REQ-005 SHALL have port in0_z, input, 32: channel 0 sample data.
REQ-006 SHALL have port in0_z_stb, input, 1: channel 0 sample valid.
REQ-007 SHALL have port in0_z_ack, output, 1: channel 0 sample taken.
REQ-008 SHALL have ports in1_z, in1_z_stb and in1_z_ack with the same directions, widths and meanings for channel 1.
REQ-009 SHALL have port out_z, output, 32: granted sample to the shared filter datapath.
REQ-010 SHALL have port out_z_ch, output, 1: channel number of out_z.
REQ-011 SHALL have port out_z_stb, output, 1: out_z valid.
REQ-012 SHALL have port out_z_ack, input, 1: filter accepted out_z.
REQ-013 SHALL have ports cnt0 and cnt1, output, 16 each: samples forwarded per channel.

Function
REQ-014 SHALL implement the FSM states IDLE, ACK, HOLD and PACE, and SHALL drive every output from a register.
REQ-015 IDLE: when enable=1 and at least one inN_z_stb=1, SHALL select a winner, load out_z<=inW_z and out_z_ch<=W, set inW_z_ack<=1, and go to ACK.
REQ-016 Winner selection: if only one stb is high, that channel wins; if both are high, the channel named by the round-robin pointer wins. The pointer resets to 0.
REQ-017 ACK: SHALL hold inW_z_ack=1 for exactly one cycle, then clear it, set out_z_stb<=1 and go to HOLD.
REQ-018 A source clears its stb on the edge where stb and ack are both high; the arbiter SHALL NOT re-sample inW during ACK.
REQ-019 HOLD: out_z, out_z_ch and out_z_stb SHALL stay stable until out_z_ack=1.
REQ-020 On the HOLD edge with out_z_ack=1, SHALL in one edge:
- clear out_z_stb;
- set the pointer to the non-winning channel;
- increment cntW, wrapping at 65535 to 0;
- go to IDLE if SAMPLE_PERIOD=1, otherwise load the pace counter with SAMPLE_PERIOD-2 and go to PACE.
REQ-021 PACE: SHALL decrement the pace counter each cycle and go to IDLE on the cycle it reads 0.
REQ-022 Minimum spacing between successive out_z_stb rising edges is SAMPLE_PERIOD+2 clocks when out_z_ack is immediate.
REQ-023 enable SHALL be sampled only in IDLE: deasserting it mid-transaction lets the transaction finish, and no new grant is made.
REQ-024 At most one inN_z_ack SHALL be high in any cycle, and never while out_z_stb=1.
REQ-025 out_z_ack while not in HOLD SHALL be ignored.
REQ-026 A stb arriving in ACK, HOLD or PACE SHALL be held off (ack=0) until the next IDLE.

Reset
REQ-027 While rst=1, regardless of clock, SHALL force:
- state IDLE and pointer 0;
- pace counter 0;
- out_z 0, out_z_ch 0, out_z_stb 0;
- in0_z_ack 0, in1_z_ack 0;
- cnt0 0, cnt1 0.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction, and no ack or stb pulse SHALL occur after reset.

Verification
REQ-029 Single channel: in0_z=0x0000_1234 stb held, out_z_ack tied 1 -> in0_z_ack one-cycle pulse, out_z=0x1234 with out_z_ch=0, cnt0=1, next out_z_stb rise 6 clocks later (SAMPLE_PERIOD=4).
REQ-030 Contention: both stb high continuously, samples 0xA (ch0) and 0xB (ch1) -> grants alternate 0,1,0,1 and after 4 grants cnt0=2, cnt1=2.
REQ-031 Backpressure: out_z_ack held 0 for 20 clocks -> out_z_stb stays 1 with out_z unchanged, no inN_z_ack pulses, and both acks stay 0 until out_z_ack=1.
REQ-032 Enable: enable dropped during HOLD -> current sample completes and cnt increments once, then no further grants while enable=0; re-enable -> arbitration resumes with the pointer preserved.
REQ-033 Wrap and reset: preload 65535 ch0 grants -> cnt0=0; rst pulsed during ACK -> all outputs 0 within the same cycle, and no stale stb follows.
REQ-034 SAMPLE_PERIOD=1 with ch1 stb held and immediate out_z_ack -> out_z_stb rises every 3 clocks.
